// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the multicycle core controller.
//   state_t      : controller state encoding (4 bits, FETCH = 0)
//   OP_*         : RV64 major opcodes recognised by the decoder
//   alu_op_t     : ALU operation select driven to the datapath
//   alu_src_b_t  : ALU operand B mux select
//   wb_sel_t     : register file writeback mux select
//   decode_target: maps an opcode to the state that follows DECODE
// ---------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC_R  = 4'd2,
      S_EXEC_I  = 4'd3,
      S_LUI     = 4'd4,
      S_ADDR    = 4'd5,
      S_MEM_RD  = 4'd6,
      S_MEM_WR  = 4'd7,
      S_WB_ALU  = 4'd8,
      S_WB_MEM  = 4'd9,
      S_BRANCH  = 4'd10,
      S_JAL     = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'd0,
      ALU_SUB    = 2'd1,
      ALU_FUNCT  = 2'd2,
      ALU_PASS_B = 2'd3
   } alu_op_t;

   typedef enum logic [1:0] {
      SRCB_REG   = 2'd0,
      SRCB_CONST = 2'd1,
      SRCB_IMM   = 2'd2
   } alu_src_b_t;

   typedef enum logic [1:0] {
      WB_ALUOUT = 2'd0,
      WB_MDR    = 2'd1,
      WB_PC     = 2'd2
   } wb_sel_t;

   // Loads and stores share the address-calculation state; anything the
   // core does not implement is routed to ILLEGAL.
   function automatic state_t decode_target(input logic [6:0] op);
      state_t target;
      case (op)
         OP_R:                target = S_EXEC_R;
         OP_IMM:              target = S_EXEC_I;
         OP_LOAD, OP_STORE:   target = S_ADDR;
         OP_BRANCH:           target = S_BRANCH;
         OP_JAL:              target = S_JAL;
         OP_LUI:              target = S_LUI;
         default:             target = S_ILLEGAL;
      endcase
      return target;
   endfunction

endpackage

// File: rtl/ctrl_next_state.sv
// ---------------------------------------------------------------------------
// ctrl_next_state
// Purely combinational next-state decoder for the multicycle controller.
// Optional macro: TRAP_ILLEGAL_EN makes ILLEGAL a terminal state; without it
// ILLEGAL returns to FETCH after one cycle.
// Ports:
//   state      in  current controller state
//   opcode     in  instr_all[6:0] from the instruction register
//   imem_ready in  instruction memory data valid
//   dmem_ready in  data memory access complete
//   state_next out state to be registered on the next clock edge
// ---------------------------------------------------------------------------
module ctrl_next_state
   import ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [6:0] opcode,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output state_t     state_next
);

   // Default is to hold the current state; each state only names the exit
   // it takes. The ready flags are looked at only in their own wait states,
   // so a stray ready pulse elsewhere has no effect.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:  if (imem_ready) state_next = S_DECODE;
         S_DECODE: state_next = decode_target(opcode);
         S_EXEC_R: state_next = S_WB_ALU;
         S_EXEC_I: state_next = S_WB_ALU;
         S_LUI:    state_next = S_WB_ALU;
         S_ADDR:   state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (dmem_ready) state_next = S_WB_MEM;
         S_MEM_WR: if (dmem_ready) state_next = S_FETCH;
         S_WB_ALU: state_next = S_FETCH;
         S_WB_MEM: state_next = S_FETCH;
         S_BRANCH: state_next = S_FETCH;
         S_JAL:    state_next = S_FETCH;
`ifdef TRAP_ILLEGAL_EN
         S_ILLEGAL: state_next = S_ILLEGAL;
`else
         S_ILLEGAL: state_next = S_FETCH;
`endif
         default:  state_next = S_FETCH;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for the 64-bit multicycle core: fetch, decode, execute,
// memory and writeback sequencing, driving every datapath enable and select.
// Optional macro: TRAP_ILLEGAL_EN -- ILLEGAL becomes terminal and the
// illegal_instr output is added.
// Parameters:
//   IMEM_WAIT_MAX  FETCH wait cycles before fetch_timeout (0 = never)
//   PC_INC         byte increment the datapath adds to PC on fetch
// Ports:
//   clk, reset                 clock, async active-high reset
//   opcode, funct3             instruction fields from instr_reg
//   alu_zero                   ALU zero flag (branch qualification)
//   imem_ready, dmem_ready     memory handshakes
//   imem_read, load_ir         fetch strobes
//   pc_write, pc_src           PC update control
//   alu_src_a, alu_src_b       ALU operand selects
//   alu_op, aluout_write       ALU operation and ALUOut enable
//   dmem_read, dmem_write      data memory strobes
//   reg_write, wb_sel          register file writeback control
//   fetch_timeout              sticky instruction-memory timeout flag
//   illegal_instr              sticky illegal opcode flag (TRAP_ILLEGAL_EN)
//   state_o                    current state encoding
// ---------------------------------------------------------------------------
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int IMEM_WAIT_MAX = 15,
   parameter int PC_INC        = 4
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       alu_zero,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_read,
   output logic       load_ir,
   output logic       pc_write,
   output logic       pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       aluout_write,
   output logic       dmem_read,
   output logic       dmem_write,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       fetch_timeout,
`ifdef TRAP_ILLEGAL_EN
   output logic       illegal_instr,
`endif
   output logic [3:0] state_o
);

   localparam int CNT_W = (IMEM_WAIT_MAX > 0) ? $clog2(IMEM_WAIT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(IMEM_WAIT_MAX);

   // The datapath adds PC_INC itself; the controller only selects the
   // constant input, so the value just has to be a sensible increment.
   if (PC_INC <= 0) begin : g_pc_inc_check
      $error("PC_INC must be a positive byte increment");
   end

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] wait_cnt;

   ctrl_next_state u_next_state (
      .state      (state),
      .opcode     (opcode),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .state_next (state_next)
   );

   // State register. Reset drops straight into FETCH so the first fetch
   // strobe is already up while reset is still asserted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // FETCH wait counter and sticky timeout. The counter only advances while
   // FETCH is stalled on imem_ready, saturates at the limit and clears as
   // soon as FETCH is left. The flag is raised on the stalled cycle that
   // brings the counter to the limit and then holds until reset; a limit of
   // zero disables the whole mechanism.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt      <= '0;
         fetch_timeout <= 1'b0;
      end else if (state == S_FETCH && !imem_ready) begin
         if (IMEM_WAIT_MAX != 0 && wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (IMEM_WAIT_MAX != 0 && wait_cnt == WAIT_LIMIT - 1'b1) begin
            fetch_timeout <= 1'b1;
         end
      end else begin
         wait_cnt <= '0;
      end
   end

`ifdef TRAP_ILLEGAL_EN
   // Illegal-instruction flag: set on the edge that enters ILLEGAL, and since
   // ILLEGAL is terminal it simply stays set until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         illegal_instr <= 1'b0;
      end else if (state_next == S_ILLEGAL) begin
         illegal_instr <= 1'b1;
      end
   end
`endif

   // Output decode. Everything defaults low; FETCH is Mealy on imem_ready so
   // the instruction register and PC update in the same cycle the memory
   // delivers, and BRANCH qualifies pc_write with the zero flag here so the
   // PC register never needs to know about branch conditions. ILLEGAL drives
   // nothing in either build.
   always_comb begin
      imem_read    = 1'b0;
      load_ir      = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = SRCB_REG;
      alu_op       = ALU_ADD;
      aluout_write = 1'b0;
      dmem_read    = 1'b0;
      dmem_write   = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = WB_ALUOUT;
      case (state)
         S_FETCH: begin
            imem_read = 1'b1;
            alu_src_b = SRCB_CONST;
            load_ir   = imem_ready;
            pc_write  = imem_ready;
         end
         S_DECODE: begin
            alu_src_b    = SRCB_IMM;
            aluout_write = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a    = 1'b1;
            alu_op       = ALU_FUNCT;
            aluout_write = 1'b1;
         end
         S_EXEC_I: begin
            alu_src_a    = 1'b1;
            alu_src_b    = SRCB_IMM;
            alu_op       = ALU_FUNCT;
            aluout_write = 1'b1;
         end
         S_LUI: begin
            alu_src_b    = SRCB_IMM;
            alu_op       = ALU_PASS_B;
            aluout_write = 1'b1;
         end
         S_ADDR: begin
            alu_src_a    = 1'b1;
            alu_src_b    = SRCB_IMM;
            aluout_write = 1'b1;
         end
         S_MEM_RD: dmem_read  = 1'b1;
         S_MEM_WR: dmem_write = 1'b1;
         S_WB_ALU: reg_write  = 1'b1;
         S_WB_MEM: begin
            reg_write = 1'b1;
            wb_sel    = WB_MDR;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 1'b1;
            case (funct3)
               3'b000:  pc_write = alu_zero;
               3'b001:  pc_write = !alu_zero;
               default: pc_write = 1'b0;
            endcase
         end
         S_JAL: begin
            reg_write = 1'b1;
            wb_sel    = WB_PC;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Instructions are described by
// class and the expected cycle-by-cycle control vector is generated from the
// instruction-class timing table, with random memory wait cycles, random
// zero flags and stray ready pulses outside the wait states.
// Build with +define+TRAP_ILLEGAL_EN to exercise the trapping build.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   localparam int WAIT_MAX = 15;

   localparam int K_R   = 0;
   localparam int K_I   = 1;
   localparam int K_LD  = 2;
   localparam int K_SD  = 3;
   localparam int K_BR  = 4;
   localparam int K_JAL = 5;
   localparam int K_LUI = 6;
   localparam int K_ILL = 7;

   typedef struct packed {
      logic [3:0] st;
      logic       imemRead;
      logic       loadIr;
      logic       pcWrite;
      logic       pcSrc;
      logic       srcA;
      logic [1:0] srcB;
      logic [1:0] aluOp;
      logic       aluoutWrite;
      logic       dmemRead;
      logic       dmemWrite;
      logic       regWrite;
      logic [1:0] wbSel;
   } ctrlVec_t;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       alu_zero;
   logic       imem_ready;
   logic       dmem_ready;
   logic       imem_read;
   logic       load_ir;
   logic       pc_write;
   logic       pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       aluout_write;
   logic       dmem_read;
   logic       dmem_write;
   logic       reg_write;
   logic [1:0] wb_sel;
   logic       fetch_timeout;
`ifdef TRAP_ILLEGAL_EN
   logic       illegal_instr;
`endif
   logic [3:0] state_o;

   int   checkCount = 0;
   int   failCount  = 0;
   int   waitRun    = 0;
   logic expTimeout = 1'b0;
   logic expIllegal = 1'b0;

   multicycle_ctrl #(.IMEM_WAIT_MAX(WAIT_MAX), .PC_INC(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .funct3        (funct3),
      .alu_zero      (alu_zero),
      .imem_ready    (imem_ready),
      .dmem_ready    (dmem_ready),
      .imem_read     (imem_read),
      .load_ir       (load_ir),
      .pc_write      (pc_write),
      .pc_src        (pc_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .aluout_write  (aluout_write),
      .dmem_read     (dmem_read),
      .dmem_write    (dmem_write),
      .reg_write     (reg_write),
      .wb_sel        (wb_sel),
      .fetch_timeout (fetch_timeout),
`ifdef TRAP_ILLEGAL_EN
      .illegal_instr (illegal_instr),
`endif
      .state_o       (state_o)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected earlier finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic ctrlVec_t observedVec();
      ctrlVec_t o;
      o.st          = state_o;
      o.imemRead    = imem_read;
      o.loadIr      = load_ir;
      o.pcWrite     = pc_write;
      o.pcSrc       = pc_src;
      o.srcA        = alu_src_a;
      o.srcB        = alu_src_b;
      o.aluOp       = alu_op;
      o.aluoutWrite = aluout_write;
      o.dmemRead    = dmem_read;
      o.dmemWrite   = dmem_write;
      o.regWrite    = reg_write;
      o.wbSel       = wb_sel;
      return o;
   endfunction

   function automatic ctrlVec_t base(input state_t st);
      ctrlVec_t e;
      e    = '0;
      e.st = st;
      return e;
   endfunction

   function automatic ctrlVec_t expFetch(input logic ready);
      ctrlVec_t e;
      e          = base(S_FETCH);
      e.imemRead = 1'b1;
      e.srcB     = 2'd1;
      e.loadIr   = ready;
      e.pcWrite  = ready;
      return e;
   endfunction

   function automatic logic [6:0] opcodeOf(input int kind);
      case (kind)
         K_R:     return 7'b0110011;
         K_I:     return 7'b0010011;
         K_LD:    return 7'b0000011;
         K_SD:    return 7'b0100011;
         K_BR:    return 7'b1100011;
         K_JAL:   return 7'b1101111;
         K_LUI:   return 7'b0110111;
         default: return 7'b1111111;
      endcase
   endfunction

   // One clock cycle: drive inputs, check the settled outputs on the falling
   // edge, then advance past the rising edge and update the timeout model.
   task automatic applyStimulus(input string tag, input ctrlVec_t e,
                                input logic imemRdy, input logic dmemRdy,
                                input logic zero, input logic [6:0] op,
                                input logic [2:0] f3);
      imem_ready = imemRdy;
      dmem_ready = dmemRdy;
      alu_zero   = zero;
      opcode     = op;
      funct3     = f3;
      @(negedge clk);
      checkOutput(tag, 32'(observedVec()), 32'(e));
      checkOutput({tag, "_timeout"}, 32'(fetch_timeout), 32'(expTimeout));
`ifdef TRAP_ILLEGAL_EN
      checkOutput({tag, "_illegal"}, 32'(illegal_instr), 32'(expIllegal));
`endif
      @(posedge clk);
      #1;
      if (e.st == 4'(S_FETCH) && !imemRdy) begin
         waitRun++;
         if (waitRun >= WAIT_MAX) expTimeout = 1'b1;
      end else begin
         waitRun = 0;
      end
   endtask

   // Runs one whole instruction of the given class with iw fetch stalls and
   // dw data-memory stalls, checking every cycle against the class table.
   task automatic runInstr(input int kind, input int iw, input int dw,
                           input logic [2:0] f3, input logic zero);
      logic [6:0] op;
      ctrlVec_t   e;
      op = opcodeOf(kind);
      for (int i = 0; i < iw; i++)
         applyStimulus("fetch_wait", expFetch(1'b0), 1'b0, 1'($urandom), zero, op, f3);
      applyStimulus("fetch", expFetch(1'b1), 1'b1, 1'($urandom), zero, op, f3);
      e = base(S_DECODE); e.srcB = 2'd2; e.aluoutWrite = 1'b1;
      applyStimulus("decode", e, 1'($urandom), 1'($urandom), zero, op, f3);
      case (kind)
         K_R, K_I, K_LUI: begin
            if (kind == K_R) begin
               e = base(S_EXEC_R); e.srcA = 1'b1; e.srcB = 2'd0; e.aluOp = 2'd2;
            end else if (kind == K_I) begin
               e = base(S_EXEC_I); e.srcA = 1'b1; e.srcB = 2'd2; e.aluOp = 2'd2;
            end else begin
               e = base(S_LUI); e.srcB = 2'd2; e.aluOp = 2'd3;
            end
            e.aluoutWrite = 1'b1;
            applyStimulus("execute", e, 1'($urandom), 1'($urandom), zero, op, f3);
            e = base(S_WB_ALU); e.regWrite = 1'b1;
            applyStimulus("wb_alu", e, 1'($urandom), 1'($urandom), zero, op, f3);
         end
         K_LD, K_SD: begin
            e = base(S_ADDR); e.srcA = 1'b1; e.srcB = 2'd2; e.aluoutWrite = 1'b1;
            applyStimulus("addr", e, 1'($urandom), 1'($urandom), zero, op, f3);
            if (kind == K_LD) begin
               e = base(S_MEM_RD); e.dmemRead = 1'b1;
            end else begin
               e = base(S_MEM_WR); e.dmemWrite = 1'b1;
            end
            for (int i = 0; i < dw; i++)
               applyStimulus("mem_wait", e, 1'($urandom), 1'b0, zero, op, f3);
            applyStimulus("mem_done", e, 1'($urandom), 1'b1, zero, op, f3);
            if (kind == K_LD) begin
               e = base(S_WB_MEM); e.regWrite = 1'b1; e.wbSel = 2'd1;
               applyStimulus("wb_mem", e, 1'($urandom), 1'($urandom), zero, op, f3);
            end
         end
         K_BR: begin
            e = base(S_BRANCH); e.srcA = 1'b1; e.aluOp = 2'd1; e.pcSrc = 1'b1;
            e.pcWrite = (f3 == 3'b000) ? zero : (f3 == 3'b001) ? !zero : 1'b0;
            applyStimulus("branch", e, 1'($urandom), 1'($urandom), zero, op, f3);
         end
         K_JAL: begin
            e = base(S_JAL); e.regWrite = 1'b1; e.wbSel = 2'd2;
            e.pcWrite = 1'b1; e.pcSrc = 1'b1;
            applyStimulus("jal", e, 1'($urandom), 1'($urandom), zero, op, f3);
         end
         default: begin
            e = base(S_ILLEGAL);
            applyStimulus("illegal", e, 1'($urandom), 1'($urandom), zero, op, f3);
         end
      endcase
   endtask

   logic [31:0] instrWord;
   ctrlVec_t    resetVec;
   int          kind;
   int          maxKind;

   initial begin
      reset      = 1'b1;
      opcode     = '0;
      funct3     = '0;
      alu_zero   = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      resetVec          = base(S_FETCH);
      resetVec.imemRead = 1'b1;
      resetVec.srcB     = 2'd1;

      // Reset state is visible before any clock edge.
      #2;
      checkOutput("reset_state", 32'(observedVec()), 32'(resetVec));
      checkOutput("reset_timeout", 32'(fetch_timeout), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      $display("[TB] reset released");

      // R-type 0x00B50533, ready immediately.
      instrWord = 32'h00B50533;
      runInstr(K_R, 0, 0, instrWord[14:12], 1'b0);
      // LD 0x00053503 with three data-memory stall cycles.
      instrWord = 32'h00053503;
      runInstr(K_LD, 0, 3, instrWord[14:12], 1'b0);
      // BEQ / BNE with both zero-flag values, plus an unsupported funct3.
      runInstr(K_BR, 0, 0, 3'b000, 1'b1);
      runInstr(K_BR, 0, 0, 3'b000, 1'b0);
      runInstr(K_BR, 0, 0, 3'b001, 1'b1);
      runInstr(K_BR, 0, 0, 3'b001, 1'b0);
      runInstr(K_BR, 0, 0, 3'b100, 1'b1);
      runInstr(K_JAL, 1, 0, 3'b000, 1'b0);
      runInstr(K_SD, 0, 2, 3'b011, 1'b0);

      // Asynchronous reset in the middle of a load's memory wait.
      begin
         ctrlVec_t e;
         applyStimulus("fetch", expFetch(1'b1), 1'b1, 1'b0, 1'b0, 7'b0000011, 3'd3);
         e = base(S_DECODE); e.srcB = 2'd2; e.aluoutWrite = 1'b1;
         applyStimulus("decode", e, 1'b0, 1'b0, 1'b0, 7'b0000011, 3'd3);
         e = base(S_ADDR); e.srcA = 1'b1; e.srcB = 2'd2; e.aluoutWrite = 1'b1;
         applyStimulus("addr", e, 1'b0, 1'b0, 1'b0, 7'b0000011, 3'd3);
         e = base(S_MEM_RD); e.dmemRead = 1'b1;
         applyStimulus("mem_rd", e, 1'b0, 1'b0, 1'b0, 7'b0000011, 3'd3);
         #2;
         reset = 1'b1;
         #1;
         checkOutput("midrd_reset_state", 32'(observedVec()), 32'(resetVec));
         checkOutput("midrd_reset_timeout", 32'(fetch_timeout), 32'd0);
         @(posedge clk);
         #1;
         reset      = 1'b0;
         waitRun    = 0;
         expTimeout = 1'b0;
      end

      // Random instruction mix with short stalls.
`ifdef TRAP_ILLEGAL_EN
      maxKind = K_LUI;
`else
      maxKind = K_ILL;
`endif
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, maxKind));
         runInstr(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  3'($urandom_range(0, 2)), 1'($urandom));
      end

      // Long instruction-memory stall: the timeout rises and sticks.
      runInstr(K_R, 20, 0, 3'b000, 1'b0);
      runInstr(K_I, 0, 0, 3'b000, 1'b0);
      checkOutput("timeout_sticky", 32'(fetch_timeout), 32'd1);

      // Unknown opcode 1111111.
`ifdef TRAP_ILLEGAL_EN
      begin
         ctrlVec_t e;
         applyStimulus("fetch", expFetch(1'b1), 1'b1, 1'b0, 1'b0, 7'b1111111, 3'd0);
         e = base(S_DECODE); e.srcB = 2'd2; e.aluoutWrite = 1'b1;
         applyStimulus("decode", e, 1'b0, 1'b0, 1'b0, 7'b1111111, 3'd0);
         expIllegal = 1'b1;
         for (int i = 0; i < 10; i++)
            applyStimulus("trap_hold", base(S_ILLEGAL), 1'b1, 1'b1, 1'b0, 7'b1111111, 3'd0);
      end
`else
      runInstr(K_ILL, 0, 0, 3'b000, 1'b0);
      runInstr(K_R, 0, 0, 3'b000, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
